onehot_encoder_pipe: RTL and testbench
======================================

ONEHOT_ENCODER_PIPE -- requirements
Module: onehot_encoder_pipe

Interface
REQ-001 Parameter N, default 8: number of one-hot input lines; SHALL be at least 2.
REQ-002 Parameter PRIORITY, default 0: 0 selects strict mode, 1 selects lowest-index priority mode.
REQ-003 Parameter CNT_W, default 8: width of the error counter.
REQ-004 Localparam W SHALL equal $clog2(N), the output code width.
REQ-005 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-006 rst  input  1  reset; asynchronous, active-high.
REQ-007 in_valid  input  1  in_data is valid this cycle.
REQ-008 in_ready  output  1  block can accept in_data this cycle.
REQ-009 in_data  input  N  one-hot input word.
REQ-010 out_valid  output  1  out_code and out_err are valid.
REQ-011 out_ready  input  1  downstream accepts the output this cycle.
REQ-012 out_code  output  W  binary index of the encoded input.
REQ-013 out_err  output  1  the encoded word was invalid for the selected mode.
REQ-014 err_count  output  CNT_W  saturating count of accepted invalid words.
REQ-015 clr_err  input  1  synchronous clear of err_count.

Function
REQ-016 A transfer in SHALL occur when in_valid and in_ready are both 1 on a rising edge.
REQ-017 A transfer out SHALL occur when out_valid and out_ready are both 1 on a rising edge.
REQ-018 in_ready SHALL be combinationally equal to (!out_valid || out_ready), giving a single-entry output register with no bubble under continuous flow.
REQ-019 Latency SHALL be 1 cycle: a word accepted at edge k SHALL present out_valid=1 with its result after edge k.
REQ-020 out_valid SHALL set on a transfer in; it SHALL clear on a transfer out without a simultaneous transfer in; simultaneous in/out SHALL keep it at 1 and load the new result.
REQ-021 While out_valid=1 and out_ready=0, out_code and out_err SHALL hold stable, in_ready SHALL be 0, and in_data SHALL be ignored.
REQ-022 Strict mode, exactly one bit i set: out_code=i, out_err=0.
REQ-023 Strict mode, zero bits or two or more bits set: out_code=0, out_err=1.
REQ-024 Priority mode, any bit set: out_code = lowest set index, out_err=0.
REQ-025 Priority mode, in_data all zero: out_code=0, out_err=1.
REQ-026 err_count SHALL increment by 1 on each transfer in whose result has out_err=1.
REQ-027 err_count SHALL saturate at 2^CNT_W-1 and SHALL NOT wrap.
REQ-028 clr_err=1 SHALL set err_count to 0 on the next edge, taking priority over a same-cycle increment.
REQ-029 When not in transfer, in_data SHALL have no effect on any state or output.

Reset
REQ-030 While rst=1: out_valid=0, out_code=0, out_err=0, err_count=0, and in_ready=1.
REQ-031 Reset assertion SHALL take effect asynchronously; a word held in the output register SHALL be discarded.
REQ-032 After rst deasserts, the first transfer in SHALL be accepted on the first rising edge.

Verification (N=8, CNT_W=8)
REQ-033 Strict mode, in_data=8'b0010_0000 with in_valid=1 and out_ready=1 -> next cycle out_valid=1, out_code=3'd5, out_err=0, err_count unchanged.
REQ-034 Strict mode, in_data=8'b0000_0110 -> out_code=0, out_err=1, err_count increments 0->1; the same word with PRIORITY=1 -> out_code=3'd1, out_err=0.
REQ-035 Backpressure: accept 8'h80, hold out_ready=0 for 3 cycles -> out_code=7 held stable, in_ready=0, a different in_data is ignored; raise out_ready -> handshake completes and in_ready=1 in that cycle.
REQ-036 Streaming: in_valid=1 and out_ready=1 for 8 cycles with in_data = 1<<k, k=0..7 -> out_code = 0..7 on consecutive cycles with no bubbles.
REQ-037 Send 300 zero words -> err_count stops at 255; then clr_err=1 in the same cycle as another zero word -> err_count=0.
REQ-038 rst pulsed mid-cycle while out_valid=1 -> out_valid=0 and err_count=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/onehot_encoder_pipe.sv
// onehot_encoder_pipe: one-hot to binary encoder behind a single-entry valid/ready output register
module onehot_encoder_pipe #(
  parameter int N = 8,
  parameter int PRIORITY = 0,
  parameter int CNT_W = 8,
  localparam int W = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_code,
  output logic             out_err,
  output logic [CNT_W-1:0] err_count,
  input  logic             clr_err
);
  logic [W-1:0] lo;
  logic         err;
  logic         take;
  assign in_ready = !out_valid || out_ready;
  assign take = in_valid && in_ready;
  // lowest set index; an error word reports code 0 in either mode
  always_comb begin
    lo = '0;
    for (int i = N - 1; i >= 0; i--) lo = in_data[i] ? W'(i) : lo;
    err = PRIORITY != 0 ? in_data == '0 : $countones(in_data) != 1;
  end
  // output register: load on accept, drain when consumed with nothing new arriving
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      out_valid <= 1'b0;
      out_code  <= '0;
      out_err   <= 1'b0;
    end else if (in_ready) begin
      out_valid <= in_valid;
      if (in_valid) begin
        out_code <= err ? '0 : lo;
        out_err  <= err;
      end
    end
  // saturating count of accepted invalid words; clear wins over increment
  always_ff @(posedge clk or posedge rst)
    if (rst) err_count <= '0;
    else if (clr_err) err_count <= '0;
    else if (take && err && err_count != '1) err_count <= err_count + 1'b1;
endmodule

// File: tb/tb_onehot_encoder_pipe.sv
// tb_onehot_encoder_pipe: strict and priority instances checked against a behavioural model
module tb_onehot_encoder_pipe;
  logic clk = 0, rst = 1, in_valid = 0, out_ready = 0, clr_err = 0;
  logic [7:0] in_data = 0;
  logic rdy_s, rdy_p, ov_s, ov_p, oe_s, oe_p;
  logic [2:0] oc_s, oc_p;
  logic [7:0] ec_s, ec_p;
  int checks = 0, errors = 0;
  bit m_valid;
  logic [2:0] m_code_s, m_code_p;
  logic m_err_s, m_err_p;
  int m_cnt_s, m_cnt_p;

  onehot_encoder_pipe #(.N(8), .PRIORITY(0), .CNT_W(8)) dut_s (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_s), .in_data(in_data),
    .out_valid(ov_s), .out_ready(out_ready), .out_code(oc_s), .out_err(oe_s),
    .err_count(ec_s), .clr_err(clr_err));
  onehot_encoder_pipe #(.N(8), .PRIORITY(1), .CNT_W(8)) dut_p (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_p), .in_data(in_data),
    .out_valid(ov_p), .out_ready(out_ready), .out_code(oc_p), .out_err(oe_p),
    .err_count(ec_p), .clr_err(clr_err));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void ref_enc(input logic [7:0] d, input bit pri, output logic [2:0] c, output logic e);
    int n = 0, first = -1;
    for (int i = 0; i < 8; i++) if (d[i]) begin n++; if (first < 0) first = i; end
    e = pri ? (n == 0) : (n != 1);
    c = e ? 3'd0 : 3'(first);
  endfunction

  function automatic int bump(input int c, input bit e, input bit t, input bit clr);
    if (clr) return 0;
    if (t && e) return c < 255 ? c + 1 : 255;
    return c;
  endfunction

  task automatic check_outputs(input string tag);
    chk({tag, ":valid_s"}, ov_s, m_valid);
    chk({tag, ":valid_p"}, ov_p, m_valid);
    chk({tag, ":code_s"}, oc_s, m_code_s);
    chk({tag, ":code_p"}, oc_p, m_code_p);
    chk({tag, ":err_s"}, oe_s, m_err_s);
    chk({tag, ":err_p"}, oe_p, m_err_p);
    chk({tag, ":cnt_s"}, ec_s, m_cnt_s);
    chk({tag, ":cnt_p"}, ec_p, m_cnt_p);
  endtask

  task automatic step(input string tag, input bit v, input logic [7:0] d, input bit r, input bit clr);
    bit rdy, t;
    logic [2:0] cs, cp;
    logic es, ep;
    in_valid = v; in_data = d; out_ready = r; clr_err = clr;
    #1;
    rdy = !m_valid || r;
    chk({tag, ":ready_s"}, rdy_s, rdy);
    chk({tag, ":ready_p"}, rdy_p, rdy);
    t = v && rdy;
    ref_enc(d, 0, cs, es);
    ref_enc(d, 1, cp, ep);
    @(posedge clk);
    m_cnt_s = bump(m_cnt_s, es, t, clr);
    m_cnt_p = bump(m_cnt_p, ep, t, clr);
    if (t) begin
      m_valid = 1; m_code_s = cs; m_err_s = es; m_code_p = cp; m_err_p = ep;
    end else if (m_valid && r) m_valid = 0;
    #1;
    check_outputs(tag);
  endtask

  task automatic model_reset();
    m_valid = 0; m_code_s = 0; m_code_p = 0; m_err_s = 0; m_err_p = 0; m_cnt_s = 0; m_cnt_p = 0;
  endtask

  initial begin
    logic [7:0] d;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_outputs("reset");
    chk("reset:ready", rdy_s, 1'b1);
    rst = 0;
    step("first", 1, 8'b0010_0000, 1, 0);
    step("bad_two", 1, 8'b0000_0110, 1, 0);
    step("drain", 0, 8'h00, 1, 0);
    step("bp_load", 1, 8'h80, 1, 0);
    for (int k = 0; k < 3; k++) step("bp_hold", 1, 8'h00, 0, 0);
    step("bp_release", 0, 8'h01, 1, 0);
    for (int k = 0; k < 8; k++) step("stream", 1, 8'(1 << k), 1, 0);
    step("stream_end", 0, 8'h00, 1, 0);
    for (int k = 0; k < 200; k++) begin
      case ($urandom_range(0, 3))
        0: d = 8'(1 << $urandom_range(0, 7));
        1: d = 8'($urandom);
        2: d = 8'h00;
        default: d = 8'(1 << $urandom_range(0, 7)) | 8'(1 << $urandom_range(0, 7));
      endcase
      step("random", 1'($urandom), d, $urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0);
    end
    for (int k = 0; k < 300; k++) step("sat", 1, 8'h00, 1, 0);
    chk("sat:count", ec_s, 8'd255);
    step("clr", 1, 8'h00, 1, 1);
    step("post_clr", 1, 8'h00, 1, 0);
    step("load_for_rst", 1, 8'h40, 0, 0);
    #2 rst = 1;
    #1;
    model_reset();
    check_outputs("async_rst");
    chk("async_rst:ready", rdy_p, 1'b1);
    @(posedge clk);
    #1 rst = 0;
    step("after_rst", 1, 8'h08, 1, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
